// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths and the operand-forwarding source select.
package cpu_pkg;

  localparam int CPU_XLEN   = 32;
  localparam int CPU_NREG   = 32;
  localparam int CPU_AW     = 5;
  localparam int CPU_CTRL_W = 24;
  localparam int CPU_CNT_W  = 32;

  typedef enum logic [2:0] {
    FWD_ZERO,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_RF
  } fwd_sel_e;

  // Youngest producer wins; x0 beats everything so it can never be forwarded into.
  function automatic fwd_sel_e fwd_pick(input logic is_zero, input logic ex_hit,
                                        input logic mem_hit, input logic wb_hit);
    if (is_zero)      return FWD_ZERO;
    else if (ex_hit)  return FWD_EX;
    else if (mem_hit) return FWD_MEM;
    else if (wb_hit)  return FWD_WB;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/id_operand_stage_if.sv
// Decoded-instruction input channel and ID->EX output channel of the operand stage.
interface id_operand_stage_if
  import cpu_pkg::*;
#(
  parameter int XLEN   = CPU_XLEN,
  parameter int AW     = CPU_AW,
  parameter int CTRL_W = CPU_CTRL_W
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [AW-1:0]     in_rs1;
  logic [AW-1:0]     in_rs2;
  logic              in_use_rs1;
  logic              in_use_rs2;
  logic [AW-1:0]     in_rd;
  logic [XLEN-1:0]   in_imm;
  logic [CTRL_W-1:0] in_ctrl;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_imm;
  logic [XLEN-1:0]   out_rs1_data;
  logic [XLEN-1:0]   out_rs2_data;
  logic [AW-1:0]     out_rs1;
  logic [AW-1:0]     out_rs2;
  logic [AW-1:0]     out_rd;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_pc, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_imm, in_ctrl,
    output out_ready,
    input  in_ready,
    input  out_valid, out_pc, out_imm, out_rs1_data, out_rs2_data, out_rs1, out_rs2, out_rd, out_ctrl
  );

  modport slave (
    input  in_valid, in_pc, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_imm, in_ctrl,
    input  out_ready,
    output in_ready,
    output out_valid, out_pc, out_imm, out_rs1_data, out_rs2_data, out_rs1, out_rs2, out_rd, out_ctrl
  );

endinterface

// File: rtl/regfile_2r1w.sv
// Integer register file: two combinational read ports, one synchronous write port, x0 reads zero.
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int XLEN    = CPU_XLEN,
  parameter int NUM_REG = CPU_NREG,
  parameter int AW      = CPU_AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] regs_reg [NUM_REG];

  // Entry 0 is reset and never written, so it always reads back zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REG; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs_reg[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_reg[raddr_a];
  assign rdata_b = regs_reg[raddr_b];

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: register file, EX/MEM/WB forwarding, load-use stall and ID->EX register.
module id_operand_stage
  import cpu_pkg::*;
#(
  parameter int XLEN    = CPU_XLEN,
  parameter int NUM_REG = CPU_NREG,
  parameter int AW      = CPU_AW,
  parameter int CTRL_W  = CPU_CTRL_W,
  parameter int CNT_W   = CPU_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  id_operand_stage_if.slave bus,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_regwrite,
  input  logic              ex_is_load,
  input  logic [AW-1:0]     ex_rd,
  input  logic [XLEN-1:0]   ex_data,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic [AW-1:0]     mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [AW-1:0]   src_addr     [2];
  logic            src_use      [2];
  logic [XLEN-1:0] rf_data      [2];
  logic [XLEN-1:0] op_data      [2];
  logic            src_conflict [2];

  logic              out_valid_reg;
  logic [XLEN-1:0]   out_pc_reg;
  logic [XLEN-1:0]   out_imm_reg;
  logic [XLEN-1:0]   out_rs1_data_reg;
  logic [XLEN-1:0]   out_rs2_data_reg;
  logic [AW-1:0]     out_rs1_reg;
  logic [AW-1:0]     out_rs2_reg;
  logic [AW-1:0]     out_rd_reg;
  logic [CTRL_W-1:0] out_ctrl_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;

  logic in_ready_int;
  logic accept;

  assign src_addr[0] = bus.in_rs1;
  assign src_addr[1] = bus.in_rs2;
  assign src_use[0]  = bus.in_use_rs1;
  assign src_use[1]  = bus.in_use_rs2;

  regfile_2r1w #(
    .XLEN    (XLEN),
    .NUM_REG (NUM_REG),
    .AW      (AW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_we),
    .waddr   (wb_rd),
    .wdata   (wb_data),
    .raddr_a (src_addr[0]),
    .rdata_a (rf_data[0]),
    .raddr_b (src_addr[1]),
    .rdata_b (rf_data[1])
  );

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic            ex_hit;
      logic            mem_hit;
      logic            wb_hit;
      fwd_sel_e        sel;
      logic [XLEN-1:0] sel_data;

      // A load in EX has no data yet; it is handled by the stall, not by forwarding.
      assign ex_hit  = ex_valid & ex_regwrite & ~ex_is_load & (ex_rd == src_addr[gi]);
      assign mem_hit = mem_valid & mem_regwrite & (mem_rd == src_addr[gi]);
      assign wb_hit  = wb_we & (wb_rd == src_addr[gi]);
      assign sel     = fwd_pick(src_addr[gi] == '0, ex_hit, mem_hit, wb_hit);

      always_comb begin
        sel_data = rf_data[gi];
        case (sel)
          FWD_ZERO: sel_data = '0;
          FWD_EX:   sel_data = ex_data;
          FWD_MEM:  sel_data = mem_data;
          FWD_WB:   sel_data = wb_data;
          default:  sel_data = rf_data[gi];
        endcase
      end

      assign op_data[gi]      = sel_data;
      assign src_conflict[gi] = src_use[gi] & (ex_rd == src_addr[gi]);
    end
  endgenerate

  assign hazard_stall = bus.in_valid & ex_valid & ex_is_load & ex_regwrite & (ex_rd != '0) &
                        (src_conflict[0] | src_conflict[1]);

  // Flush always consumes the incoming beat so decode can move on to the redirected stream.
  assign in_ready_int = flush | ((~out_valid_reg | bus.out_ready) & ~hazard_stall);
  assign accept       = bus.in_valid & in_ready_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg    <= 1'b0;
      out_pc_reg       <= '0;
      out_imm_reg      <= '0;
      out_rs1_data_reg <= '0;
      out_rs2_data_reg <= '0;
      out_rs1_reg      <= '0;
      out_rs2_reg      <= '0;
      out_rd_reg       <= '0;
      out_ctrl_reg     <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg    <= 1'b1;
      out_pc_reg       <= bus.in_pc;
      out_imm_reg      <= bus.in_imm;
      out_rs1_data_reg <= op_data[0];
      out_rs2_data_reg <= op_data[1];
      out_rs1_reg      <= bus.in_rs1;
      out_rs2_reg      <= bus.in_rs2;
      out_rd_reg       <= bus.in_rd;
      out_ctrl_reg     <= bus.in_ctrl;
    end else if (bus.out_ready && out_valid_reg) begin
      out_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (hazard_stall && !flush && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign bus.in_ready     = in_ready_int;
  assign bus.out_valid    = out_valid_reg;
  assign bus.out_pc       = out_pc_reg;
  assign bus.out_imm      = out_imm_reg;
  assign bus.out_rs1_data = out_rs1_data_reg;
  assign bus.out_rs2_data = out_rs2_data_reg;
  assign bus.out_rs1      = out_rs1_reg;
  assign bus.out_rs2      = out_rs2_reg;
  assign bus.out_rd       = out_rd_reg;
  assign bus.out_ctrl     = out_ctrl_reg;
  assign stall_cnt        = stall_cnt_reg;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: reference model checked every cycle plus hand-computed checks.
module tb_id_operand_stage;

  localparam int XLEN    = 32;
  localparam int NUM_REG = 32;
  localparam int AW      = 5;
  localparam int CTRL_W  = 24;
  localparam int CNT_W   = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_operand_stage_if #(.XLEN(XLEN), .AW(AW), .CTRL_W(CTRL_W)) bus();

  logic            flush;
  logic            ex_valid, ex_regwrite, ex_is_load;
  logic [AW-1:0]   ex_rd;
  logic [XLEN-1:0] ex_data;
  logic            mem_valid, mem_regwrite;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            hazard_stall;
  logic [CNT_W-1:0] stall_cnt;

  id_operand_stage #(
    .XLEN(XLEN), .NUM_REG(NUM_REG), .AW(AW), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_data(ex_data),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [XLEN-1:0]   m_rf [NUM_REG];
  logic              m_valid = 1'b0;
  logic [XLEN-1:0]   m_pc = '0, m_imm = '0, m_d1 = '0, m_d2 = '0;
  logic [AW-1:0]     m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  logic [CTRL_W-1:0] m_ctrl = '0;
  logic [CNT_W-1:0]  m_cnt = '0;

  initial for (int i = 0; i < NUM_REG; i++) m_rf[i] = '0;

  function automatic logic [XLEN-1:0] m_operand(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (ex_valid && ex_regwrite && !ex_is_load && ex_rd == a) return ex_data;
    if (mem_valid && mem_regwrite && mem_rd == a) return mem_data;
    if (wb_we && wb_rd == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic logic m_hazard();
    if (!(bus.in_valid && ex_valid && ex_is_load && ex_regwrite && ex_rd != 0)) return 1'b0;
    return (bus.in_use_rs1 && ex_rd == bus.in_rs1) || (bus.in_use_rs2 && ex_rd == bus.in_rs2);
  endfunction

  function automatic logic m_ready();
    return flush || ((!m_valid || bus.out_ready) && !m_hazard());
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_pc <= '0; m_imm <= '0; m_d1 <= '0; m_d2 <= '0;
      m_rs1 <= '0; m_rs2 <= '0; m_rd <= '0; m_ctrl <= '0; m_cnt <= '0;
      for (int i = 0; i < NUM_REG; i++) m_rf[i] <= '0;
    end else begin
      if (flush) m_valid <= 1'b0;
      else if (bus.in_valid && m_ready()) begin
        m_valid <= 1'b1;
        m_pc <= bus.in_pc;   m_imm <= bus.in_imm;  m_ctrl <= bus.in_ctrl;
        m_rs1 <= bus.in_rs1; m_rs2 <= bus.in_rs2;  m_rd <= bus.in_rd;
        m_d1 <= m_operand(bus.in_rs1);
        m_d2 <= m_operand(bus.in_rs2);
      end else if (bus.out_ready) m_valid <= 1'b0;
      if (m_hazard() && !flush && m_cnt != {CNT_W{1'b1}}) m_cnt <= m_cnt + 1;
      if (wb_we && wb_rd != 0) m_rf[wb_rd] <= wb_data;
    end
  end

  always @(negedge clk) begin
    chk("in_ready",     bus.in_ready,     m_ready());
    chk("hazard_stall", hazard_stall,     m_hazard());
    chk("out_valid",    bus.out_valid,    m_valid);
    chk("out_pc",       bus.out_pc,       m_pc);
    chk("out_imm",      bus.out_imm,      m_imm);
    chk("out_rs1_data", bus.out_rs1_data, m_d1);
    chk("out_rs2_data", bus.out_rs2_data, m_d2);
    chk("out_rs1",      bus.out_rs1,      m_rs1);
    chk("out_rs2",      bus.out_rs2,      m_rs2);
    chk("out_rd",       bus.out_rd,       m_rd);
    chk("out_ctrl",     bus.out_ctrl,     m_ctrl);
    chk("stall_cnt",    stall_cnt,        m_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.in_pc = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
    bus.in_use_rs1 = 0; bus.in_use_rs2 = 0; bus.in_rd = 0; bus.in_imm = 0; bus.in_ctrl = 0;
    flush = 0;
    ex_valid = 0; ex_regwrite = 0; ex_is_load = 0; ex_rd = 0; ex_data = 0;
    mem_valid = 0; mem_regwrite = 0; mem_rd = 0; mem_data = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  initial begin
    idle();
    bus.out_ready = 1;
    rst_n = 0;
    @(negedge clk);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_out_pc", bus.out_pc, 0);
    cyc();
    rst_n = 1;

    // Forwarding priority EX > MEM > WB > regfile
    cyc();
    bus.in_valid = 1; bus.in_pc = 32'h1000; bus.in_rs1 = 5; bus.in_use_rs1 = 1; bus.in_rd = 9;
    bus.in_imm = 32'h44; bus.in_ctrl = 24'h00A5A5;
    ex_valid = 1; ex_regwrite = 1; ex_rd = 5; ex_data = 32'hAAAA;
    mem_valid = 1; mem_regwrite = 1; mem_rd = 5; mem_data = 32'hBBBB;
    wb_we = 1; wb_rd = 5; wb_data = 32'hCCCC;
    cyc();
    ex_valid = 0; bus.in_pc = 32'h1004;
    @(negedge clk); chk("fwd_ex", bus.out_rs1_data, 32'hAAAA);
    cyc();
    mem_valid = 0; bus.in_pc = 32'h1008;
    @(negedge clk); chk("fwd_mem", bus.out_rs1_data, 32'hBBBB);
    cyc();
    wb_we = 0; bus.in_pc = 32'h100C;
    @(negedge clk); chk("fwd_wb", bus.out_rs1_data, 32'hCCCC);
    cyc();
    @(negedge clk); chk("rf_read_x5", bus.out_rs1_data, 32'hCCCC);

    // Load-use stall on rs2, then the same with rs2 unused
    cyc();
    bus.in_rs1 = 0; bus.in_use_rs1 = 0; bus.in_rs2 = 7; bus.in_use_rs2 = 1;
    ex_valid = 1; ex_regwrite = 1; ex_is_load = 1; ex_rd = 7; ex_data = 32'hDEAD;
    @(negedge clk);
    chk("lu_hazard", hazard_stall, 1);
    chk("lu_in_ready", bus.in_ready, 0);
    cyc();
    bus.in_use_rs2 = 0;
    @(negedge clk);
    chk("lu_bubble", bus.out_valid, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("nouse_hazard", hazard_stall, 0);
    chk("nouse_in_ready", bus.in_ready, 1);
    cyc();
    @(negedge clk);
    chk("nouse_out_valid", bus.out_valid, 1);
    chk("nouse_no_load_fwd", bus.out_rs2_data, 0);

    // x0 never forwarded or written
    cyc();
    ex_is_load = 0; ex_rd = 0; ex_data = 32'h5555;
    wb_we = 1; wb_rd = 0; wb_data = 32'h1234;
    bus.in_rs1 = 0; bus.in_use_rs1 = 1; bus.in_rs2 = 0; bus.in_use_rs2 = 1;
    cyc();
    wb_we = 0; ex_valid = 0; ex_regwrite = 0;
    @(negedge clk);
    chk("x0_rs1", bus.out_rs1_data, 0);
    chk("x0_rs2", bus.out_rs2_data, 0);

    // Backpressure: payload held, incoming beat not lost
    cyc();
    bus.in_pc = 32'h100; bus.in_imm = 32'h11; bus.in_ctrl = 24'hABCDE; bus.in_rs1 = 5;
    cyc();
    bus.out_ready = 0; bus.in_pc = 32'h200; bus.in_imm = 32'h22; bus.in_ctrl = 24'h123;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_pc", bus.out_pc, 32'h100);
      chk("bp_out_ctrl", bus.out_ctrl, 24'hABCDE);
      chk("bp_out_rs1_data", bus.out_rs1_data, 32'hCCCC);
      cyc();
    end
    bus.out_ready = 1;
    @(negedge clk); chk("bp_release_ready", bus.in_ready, 1);
    cyc();
    @(negedge clk);
    chk("bp_next_pc", bus.out_pc, 32'h200);
    chk("bp_next_imm", bus.out_imm, 32'h22);

    // Flush while holding and presenting a beat
    cyc();
    bus.out_ready = 0; bus.in_pc = 32'h300; flush = 1;
    @(negedge clk); chk("flush_in_ready", bus.in_ready, 1);
    cyc();
    flush = 0; bus.in_valid = 0;
    @(negedge clk);
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_discarded", bus.out_pc, 32'h200);

    // Reset mid-stream with stall_cnt at 9
    cyc();
    bus.in_valid = 1; bus.in_pc = 32'h600; bus.in_rs1 = 3; bus.in_use_rs1 = 1;
    bus.in_rs2 = 0; bus.in_use_rs2 = 0;
    cyc();
    ex_valid = 1; ex_regwrite = 1; ex_is_load = 1; ex_rd = 3;
    repeat (8) cyc();
    @(negedge clk);
    chk("pre_rst_stall_cnt", stall_cnt, 9);
    chk("pre_rst_out_valid", bus.out_valid, 1);
    chk("pre_rst_out_pc", bus.out_pc, 32'h600);
    #1 rst_n = 0;
    #1;
    chk("async_rst_out_valid", bus.out_valid, 0);
    chk("async_rst_stall_cnt", stall_cnt, 0);
    idle();
    cyc();
    rst_n = 1;
    bus.out_ready = 1; bus.in_valid = 1; bus.in_rs1 = 5; bus.in_use_rs1 = 1;
    cyc();
    bus.in_valid = 0;
    @(negedge clk);
    chk("post_rst_rf_x5", bus.out_rs1_data, 0);
    chk("post_rst_out_valid", bus.out_valid, 1);
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
